// File: rtl/uitpg_multi.sv
// Parametrised video test-pattern generator: regenerates RGB on incoming VS/HS/DE timing.
// Optional feature macro: TPG_BORDER_EN adds a 1-pixel white frame border over every pattern.
module uitpg_multi #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned H_ACTIVE   = 1920,
    parameter int unsigned V_ACTIVE   = 1080,
    parameter int unsigned GRID_SHIFT = 4,
    parameter int unsigned BOX_SIZE   = 64,
    parameter int unsigned MODE_HOLD  = 16,
    parameter bit          SYNC_POL   = 1'b1
) (
    input  logic                I_tpg_clk,
    input  logic                I_tpg_rstn,
    input  logic                I_tpg_vs,
    input  logic                I_tpg_hs,
    input  logic                I_tpg_de,
    input  logic [3:0]          I_mode_sel,
    input  logic                I_auto_en,
    output logic                O_tpg_vs,
    output logic                O_tpg_hs,
    output logic                O_tpg_de,
    output logic [3*DATA_W-1:0] O_tpg_data,
    output logic [3:0]          O_dis_mode,
    output logic                O_frame_start
);

    localparam int unsigned MAX_HV = (H_ACTIVE > V_ACTIVE) ? H_ACTIVE : V_ACTIVE;
    localparam int unsigned PW     = $clog2(MAX_HV + BOX_SIZE + 1);
    localparam int unsigned GW     = GRID_SHIFT + 1;
    localparam int unsigned AW     = (PW > DATA_W) ? PW : DATA_W;
    localparam int unsigned CW     = (AW > GW) ? AW : GW;
    localparam int unsigned FW     = (MODE_HOLD > 1) ? $clog2(MODE_HOLD) : 1;

    localparam logic [CW-1:0] H_MAX = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] V_MAX = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] X_LIM = CW'(H_ACTIVE - BOX_SIZE);
    localparam logic [CW-1:0] Y_LIM = CW'(V_ACTIVE - BOX_SIZE);
    localparam logic [CW-1:0] BOX   = CW'(BOX_SIZE);
    localparam logic [CW-1:0] BAR_W = CW'(H_ACTIVE / 8);
    localparam logic [FW-1:0] F_MAX = FW'(MODE_HOLD - 1);

    logic                vs_q, hs_q, de_q, fs_q;
    logic                fs_d;
    logic [3*DATA_W-1:0] data_q, data_d;
    logic [3:0]          mode_q, mode_d;
    logic [FW-1:0]       fcnt_q, fcnt_d;
    logic [CW-1:0]       h_q, h_d, v_q, v_d;
    logic [CW-1:0]       bx_q, bx_d, by_q, by_d;
    logic                bx_dir_q, bx_dir_d, by_dir_q, by_dir_d;

    // Returns {dir, pos}; dir 0 = increasing. Reverses instead of stepping out of [0, lim].
    function automatic logic [CW:0] box_step(input logic [CW-1:0] pos, input logic dir,
                                             input logic [CW-1:0] lim);
        logic [CW-1:0] p;
        logic          d;
        p = pos;
        d = dir;
        if (!dir) begin
            if (pos >= lim) begin
                d = 1'b1;
                if (pos != '0) p = pos - 1'b1;
            end else begin
                p = pos + 1'b1;
            end
        end else begin
            if (pos == '0) begin
                d = 1'b0;
                if (lim != '0) p = pos + 1'b1;
            end else begin
                p = pos - 1'b1;
            end
        end
        return {d, p};
    endfunction

    always_comb begin
        logic vs_act, vs_act_q;
        vs_act   = SYNC_POL ? I_tpg_vs : ~I_tpg_vs;
        vs_act_q = SYNC_POL ? vs_q : ~vs_q;
        fs_d     = vs_act & ~vs_act_q;

        h_d = '0;
        if (I_tpg_de) h_d = (h_q < H_MAX) ? h_q + 1'b1 : h_q;

        v_d = v_q;
        if (fs_d) begin
            v_d = '0;
        end else if (!I_tpg_de && de_q && (v_q < V_MAX)) begin
            v_d = v_q + 1'b1;
        end

        mode_d                 = mode_q;
        fcnt_d                 = fcnt_q;
        {bx_dir_d, bx_d}       = {bx_dir_q, bx_q};
        {by_dir_d, by_d}       = {by_dir_q, by_q};
        if (fs_d) begin
            {bx_dir_d, bx_d} = box_step(bx_q, bx_dir_q, X_LIM);
            {by_dir_d, by_d} = box_step(by_q, by_dir_q, Y_LIM);
            if (I_auto_en) begin
                if (fcnt_q >= F_MAX) begin
                    fcnt_d = '0;
                    mode_d = (mode_q >= 4'd9) ? 4'd0 : mode_q + 4'd1;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end else begin
                fcnt_d = '0;
                mode_d = (I_mode_sel > 4'd9) ? 4'd0 : I_mode_sel;
            end
        end
    end

    // Pattern for the pixel currently on the input; h_q/v_q already point at it.
    always_comb begin
        logic [DATA_W-1:0] r, g, b;
        logic [CW-1:0]     bar_div;
        logic [2:0]        bar_idx;
        logic              in_box;
        r       = '0;
        g       = '0;
        b       = '0;
        bar_div = h_q / BAR_W;
        bar_idx = (bar_div > CW'(7)) ? 3'd7 : bar_div[2:0];
        in_box  = (h_q >= bx_q) && (h_q < bx_q + BOX) && (v_q >= by_q) && (v_q < by_q + BOX);
        case (mode_q)
            4'd1: begin r = '1; g = '1; b = '1; end
            4'd2: r = '1;
            4'd3: g = '1;
            4'd4: b = '1;
            4'd5: begin
                if (h_q[GRID_SHIFT] == v_q[GRID_SHIFT]) begin
                    r = '1; g = '1; b = '1;
                end
            end
            4'd6: begin r = h_q[DATA_W-1:0]; g = h_q[DATA_W-1:0]; b = h_q[DATA_W-1:0]; end
            4'd7: begin r = v_q[DATA_W-1:0]; g = v_q[DATA_W-1:0]; b = v_q[DATA_W-1:0]; end
            4'd8: begin
                // Bar order white,yellow,cyan,green,magenta,red,blue,black falls out of idx bits.
                r = {DATA_W{~bar_idx[1]}};
                g = {DATA_W{~bar_idx[2]}};
                b = {DATA_W{~bar_idx[0]}};
            end
            4'd9: begin
                b = '1;
                if (in_box) begin
                    r = '1; g = '1;
                end
            end
            default: ;
        endcase
`ifdef TPG_BORDER_EN
        if ((h_q == '0) || (h_q == H_MAX) || (v_q == '0) || (v_q == V_MAX)) begin
            r = '1; g = '1; b = '1;
        end
`endif
        data_d = I_tpg_de ? {r, g, b} : '0;
    end

    always_ff @(posedge I_tpg_clk or negedge I_tpg_rstn) begin
        if (!I_tpg_rstn) begin
            vs_q     <= 1'b0;
            hs_q     <= 1'b0;
            de_q     <= 1'b0;
            fs_q     <= 1'b0;
            data_q   <= '0;
            mode_q   <= '0;
            fcnt_q   <= '0;
            h_q      <= '0;
            v_q      <= '0;
            bx_q     <= '0;
            by_q     <= '0;
            bx_dir_q <= 1'b0;
            by_dir_q <= 1'b0;
        end else begin
            vs_q     <= I_tpg_vs;
            hs_q     <= I_tpg_hs;
            de_q     <= I_tpg_de;
            fs_q     <= fs_d;
            data_q   <= data_d;
            mode_q   <= mode_d;
            fcnt_q   <= fcnt_d;
            h_q      <= h_d;
            v_q      <= v_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            bx_dir_q <= bx_dir_d;
            by_dir_q <= by_dir_d;
        end
    end

    assign O_tpg_vs      = vs_q;
    assign O_tpg_hs      = hs_q;
    assign O_tpg_de      = de_q;
    assign O_tpg_data    = data_q;
    assign O_dis_mode    = mode_q;
    assign O_frame_start = fs_q;

endmodule
